// File: rtl/fetch_buffer.sv
// ============================================================================
// Module      : fetch_buffer
// Description : Instruction fetch queue. Walks a sequential fetch PC through
//               instruction memory, buffers {pc, instr, misaligned} entries in
//               a circular FIFO for decode, and flushes/retargets on redirect.
//               Optional feature macro: FETCH_MISALIGN_CHECK_EN. When defined,
//               a misaligned fetch PC pushes a single marker entry and halts
//               fetch until the next redirect. When it is not defined,
//               redirect targets are forced word-aligned instead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef XLEN
`define XLEN 32
`endif

module fetch_buffer #(
    parameter int              XLEN     = `XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            out_misaligned
);

    localparam int              PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CNT_W       = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_full     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);
    localparam logic [XLEN-1:0] c_pc_step   = XLEN'(4);
    localparam logic [XLEN-1:0] c_word_mask = ~(XLEN'(3));
    localparam logic [31:0]     c_nop_instr = 32'h0000_0013;

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_HALT  = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic             w_fetch_en;

    logic [XLEN-1:0]  r_fetch_pc;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic             w_room;
    logic             w_fetch_misaligned;
    logic             w_mis_push;
    logic [31:0]      w_push_instr;
    logic [XLEN-1:0]  w_redirect_target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic             r_mis_mem [DEPTH];

    assign w_fetch_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_redirect_target  = redirect_pc;
    assign out_misaligned     = out_valid && r_mis_mem[r_head];

    // Marker flag storage travels alongside the pc/instr entry
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mis_mem[r_tail] <= w_fetch_misaligned;
        end
    end
`else
    // Low target bits dropped so the fetch PC can never become misaligned
    assign w_fetch_misaligned = 1'b0;
    assign w_redirect_target  = redirect_pc & c_word_mask;
    assign out_misaligned     = 1'b0;
`endif

    // Handshake and push qualification; a pop frees a slot in the same cycle
    assign w_pop        = out_valid && out_ready;
    assign w_room       = (r_count != c_full) || w_pop;
    assign w_push       = w_fetch_en && !redirect_valid && w_room;
    assign w_mis_push   = w_push && w_fetch_misaligned;
    assign w_push_instr = w_fetch_misaligned ? c_nop_instr : imem_instr;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: redirect always resumes fetch, marker push halts it
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = S_FETCH;
        end else if (w_mis_push) begin
            w_state_next = S_HALT;
        end
    end

    // FSM outputs: fetching is only enabled in the FETCH state
    always_comb begin
        w_fetch_en = 1'b0;
        if (r_state == S_FETCH) begin
            w_fetch_en = 1'b1;
        end
    end

    // Queue pointers, occupancy and fetch PC; redirect flushes everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= RESET_PC;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_ptr_one;
            end
            if (w_pop) begin
                r_head <= r_head + c_ptr_one;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_cnt_one;
            end
            // A marker push leaves the PC parked on the faulting address
            if (w_push && !w_fetch_misaligned) begin
                r_fetch_pc <= r_fetch_pc + c_pc_step;
            end
        end
    end

    // Entry payload storage; contents are only observed behind out_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_tail]    <= r_fetch_pc;
            r_instr_mem[r_tail] <= w_push_instr;
        end
    end

    assign imem_addr = r_fetch_pc;
    assign out_valid = (r_count != '0);
    assign out_pc    = r_pc_mem[r_head];
    assign out_instr = r_instr_mem[r_head];

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Self-checking bench for fetch_buffer. A queue-based reference
//               model of the fetch stream is advanced every clock and compared
//               against the DUT outputs after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } entry_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misaligned;

    int          total;
    int          bad;

    entry_t      q[$];
    logic [31:0] m_pc;
    logic        m_halt;

    fetch_buffer #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_misaligned (out_misaligned)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0000_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    // {valid, pc, instr, mis, fetch address}; payload masked when empty
    function automatic logic [97:0] exp_obs();
        entry_t e;
        e = '0;
        if (q.size() > 0) e = q[0];
        return {q.size() > 0, e.pc, e.instr, e.mis, m_pc};
    endfunction

    function automatic logic [97:0] dut_obs();
        return {out_valid,
                out_valid ? out_pc : 32'h0,
                out_valid ? out_instr : 32'h0,
                out_valid ? out_misaligned : 1'b0,
                imem_addr};
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = RESET_PC;
        m_halt = 1'b0;
    endtask

    // Advance the model by one cycle using the current inputs, then clock DUT
    task automatic step();
        entry_t e;
        logic   mis;
        if ((q.size() > 0) && out_ready) void'(q.pop_front());
        if (redirect_valid) begin
            q.delete();
            m_halt = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            m_pc = redirect_pc;
`else
            m_pc = redirect_pc & ~32'h3;
`endif
        end else if (!m_halt && q.size() < DEPTH) begin
            mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis = (m_pc[1:0] != 2'b00);
`endif
            e.pc = m_pc;
            e.mis = mis;
            if (mis) begin
                e.instr = 32'h0000_0013;
                m_halt  = 1'b1;
            end else begin
                e.instr = mem_word(m_pc);
                m_pc    = m_pc + 32'd4;
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        reset_n        = 1'b0;
        #2;
        model_reset();
        total++;
        if (dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL reset_state: got %h want %h", dut_obs(), exp_obs());
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0000_0093) begin
            bad++;
            $display("FAIL first_push: got v=%b pc=%h instr=%h want v=1 pc=0 instr=00000093",
                     out_valid, out_pc, out_instr);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL stream cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            total++;
            if (dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL stall cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        total++;
        if (imem_addr !== 32'h10 || out_pc !== 32'h0) begin
            bad++;
            $display("FAIL stall_hold: got addr=%h pc=%h want addr=00000010 pc=0", imem_addr, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (out_pc !== 32'(4 * (i + 1)) || dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL drain cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] old_head;
        out_ready = 1'b0;
        repeat (5) step();
        old_head  = q[0].pc;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if (out_pc !== old_head + 32'd4 || dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL full_push_pop: got %h want %h", dut_obs(), exp_obs());
        end
        step();
        total++;
        if (q.size() != DEPTH || dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL full_hold: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_redirect();
        do_reset();
        out_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL redirect_bubble: got %h want %h", dut_obs(), exp_obs());
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
            bad++;
            $display("FAIL redirect_first: got v=%b pc=%h want v=1 pc=00000200", out_valid, out_pc);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || out_pc !== 32'h204 || dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL redirect_second: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_unaligned_redirect();
        logic [31:0] want_pc;
        logic        want_mis;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        want_pc  = 32'h102;
        want_mis = 1'b1;
`else
        want_pc  = 32'h100;
        want_mis = 1'b0;
`endif
        total++;
        if (out_pc !== want_pc || out_misaligned !== want_mis || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL unaligned: got pc=%h mis=%b want pc=%h mis=%b",
                     out_pc, out_misaligned, want_pc, want_mis);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL unaligned_after cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        step();
        total++;
        if (out_pc !== 32'h300 || dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL resume_300: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        out_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if (dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL wrap cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b1;
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_misaligned !== 1'b0 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL mid_reset: got v=%b mis=%b addr=%h want v=0 mis=0 addr=%h",
                     out_valid, out_misaligned, imem_addr, RESET_PC);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step();
        total++;
        if (dut_obs() !== exp_obs()) begin
            bad++;
            $display("FAIL after_mid_reset: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = (i % 3 == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            step();
            total++;
            if (dut_obs() !== exp_obs()) begin
                bad++;
                $display("FAIL random cyc=%0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        test_reset();
        test_backpressure();
        test_full_push_pop();
        test_redirect();
        test_unaligned_redirect();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter XLEN, default `XLEN, address/PC width (32 or 64).
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port imem_addr  output  XLEN  fetch address to instruction memory; equals the fetch_pc register.
REQ-007 Port imem_instr  input  32  instruction returned combinationally for imem_addr in the same cycle.
REQ-008 Port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-009 Port redirect_pc  input  XLEN  redirect target.
REQ-010 Port out_valid  output  1  queue head holds a valid entry.
REQ-011 Port out_ready  input  1  decode accepts the head entry.
REQ-012 Port out_instr  output  32  head instruction.
REQ-013 Port out_pc  output  XLEN  PC of the head instruction.
REQ-014 Port out_misaligned  output  1  head entry is a misaligned-fetch marker.

Function
REQ-015 Circular FIFO of DEPTH entries {pc, instr, misaligned}, with head and tail pointers wrapping modulo DEPTH and an occupancy count from 0 to DEPTH.
REQ-016 out_valid SHALL be 1 exactly when count > 0; out_instr, out_pc and out_misaligned SHALL show the head entry.
REQ-017 pop = out_valid && out_ready; push = state FETCH && !redirect_valid && (count < DEPTH || pop).
REQ-018 On push: write {fetch_pc, imem_instr, 0} at the tail, then fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN.
REQ-019 Simultaneous push and pop at count == DEPTH SHALL be accepted; count stays DEPTH.
REQ-020 Simultaneous push and pop at any count SHALL leave count unchanged.
REQ-021 Pop at count == 0 is impossible because out_valid is 0; push at count == DEPTH without pop is suppressed, and fetch_pc holds.
REQ-022 Redirect has priority: on an edge with redirect_valid == 1, the queue SHALL be flushed (count and pointers to 0), fetch_pc <= redirect_pc, state <= FETCH, and no push occurs.
REQ-023 A pop in the redirect cycle counts as a completed handshake for decode; the flush discards everything else.
REQ-024 Redirect latency: redirect at edge N gives the first push at edge N+1, and out_valid = 1 with out_pc = redirect_pc after edge N+1 (one bubble cycle).
REQ-025 Steady-state throughput SHALL be one instruction per cycle while out_ready is held at 1.
REQ-026 States are FETCH and HALT.
 - FETCH -> HALT only per REQ-030.
 - HALT -> FETCH only on redirect.
 - HALT SHALL perform no pushes.

Reset
REQ-027 While reset_n == 0, asynchronously: fetch_pc = RESET_PC, count = 0, head = tail = 0, state = FETCH, out_valid = 0, out_misaligned = 0.
REQ-028 The first push SHALL occur on the first rising edge after reset_n is released, capturing RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries with no partial output.

Configuration
REQ-030 With FETCH_MISALIGN_CHECK_EN defined:
 - when state is FETCH, fetch_pc[1:0] != 0, and a push is allowed, push {fetch_pc, 32'h00000013, 1} instead of the normal entry;
 - then enter HALT, with fetch_pc unchanged.
REQ-031 Without FETCH_MISALIGN_CHECK_EN:
 - redirect_pc[1:0] is cleared on load, so fetch_pc is always word-aligned;
 - out_misaligned is tied to 0;
 - HALT is unreachable.

Verification
REQ-032 Reset release, out_ready = 1, memory holding 0x00000093 at address 0 -> out_valid rises after edge 1 with out_pc = 0x0 and out_instr = 0x00000093; out_pc then advances by 4 per cycle.
REQ-033 out_ready = 0 for 10 cycles -> count saturates at 4, fetch_pc = 0x10 holds, no entry is lost; releasing out_ready drains PCs 0x0, 0x4, 0x8, 0xC in order, then 0x10.
REQ-034 Full queue with push and pop in the same cycle -> count stays 4 and the next out_pc is the old head + 4.
REQ-035 redirect_valid with redirect_pc = 0x200 while 3 entries are queued -> out_valid = 0 for one cycle, then out_pc = 0x200 and 0x204 on consecutive cycles.
REQ-036 With the macro defined, redirect to 0x102 -> exactly one entry with out_pc = 0x102, out_misaligned = 1, out_instr = 0x00000013; no further entries until a redirect to 0x300 resumes at 0x300.
REQ-037 Without the macro, redirect to 0x102 -> out_pc = 0x100 and out_misaligned = 0; reset asserted mid-stream -> out_valid = 0 immediately.
